// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial add/subtract engine.
package adder_pkg;

   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_RUN  = 2'd1;
   localparam logic [1:0] ENC_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ENC_IDLE,
      RUN  = ENC_RUN,
      DONE = ENC_DONE
   } state_t;

   // A single-chunk configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the ripple element.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from chained full_adder cells.
module ripple_chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (w_c[i]),
         .s    (s[i]),
         .cout (w_c[i+1])
      );
   end

   assign cout = w_c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: ripples CHUNK bits per clock, carrying the chunk carry
// between cycles. Results appear only on completion.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = cnt_width(NCH);
   localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

   // Handshake: start is accepted on a rising edge only while busy is low
   // (IDLE or DONE); the result is valid for the single cycle done is high.
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_partial;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c_out;
   logic             r_overflow;

   logic [31:0]      w_base;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_s_chunk;
   logic             w_cout;
   logic [WIDTH-1:0] w_result;

   assign w_base    = 32'(r_cnt) * 32'(CHUNK);
   assign w_a_chunk = r_a[w_base +: CHUNK];
   assign w_b_chunk = r_b[w_base +: CHUNK];

   ripple_chunk_adder #(.CHUNK(CHUNK)) u_slice (
      .a    (w_a_chunk),
      .b    (w_b_chunk),
      .cin  (r_carry),
      .s    (w_s_chunk),
      .cout (w_cout)
   );

   // Partial result with the current slice merged in; complete on the last chunk.
   always_comb begin
      w_result                   = r_partial;
      w_result[w_base +: CHUNK]  = w_s_chunk;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_partial  <= '0;
         r_carry    <= 1'b0;
         r_sum      <= '0;
         r_c_out    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a       <= in1;
                  r_b       <= sub ? ~in2 : in2;
                  r_carry   <= sub ? 1'b1 : c_in;
                  r_cnt     <= '0;
                  r_partial <= '0;
                  r_state   <= RUN;
               end else begin
                  r_state   <= IDLE;
               end
            end
            RUN: begin
               r_partial <= w_result;
               r_carry   <= w_cout;
               if (r_cnt == LAST_CNT) begin
                  r_sum      <= w_result;
                  r_c_out    <= w_cout;
                  r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                (w_result[WIDTH-1] != r_a[WIDTH-1]);
                  r_state    <= DONE;
               end else begin
                  r_cnt      <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = (r_state == RUN);
   assign done      = (r_state == DONE);
   assign sum       = r_sum;
   assign c_out     = r_c_out;
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule
